// File: rtl/mux64_rr_arbiter.sv
// mux64_rr_arbiter: round-robin owner of a shared WIDTH-bit 2:1 datapath mux.
// Two packet requesters compete for one registered output stage. A grant is held
// for a whole packet, or until MAX_BEATS beats have been accepted.
// Optional build macro MUX_ARB_STATS_EN adds per-requester release counters
// (pkt_cnt0 / pkt_cnt1).
//
// Handshake: a beat moves from requester i to the output register on a rising
// edge where ini_valid && ini_ready. ini_ready is high only while requester i
// holds the grant and the output register is empty or being drained
// (out_ready). A beat leaves the output register on an edge where
// out_valid && out_ready. Data and last are qualified only by their valid.
module mux64_rr_arbiter #(
    parameter int WIDTH     = 64,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_last,
    input  logic             out_ready,
    output logic             mux_sel,
    output logic             overrun,
    output logic [1:0]       state_dbg
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [31:0]      pkt_cnt0,
    output logic [31:0]      pkt_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   beat_cnt;
    logic               last_grant;

    logic               can_load;
    logic               acc;
    logic               acc_src;
    logic               acc_last;
    logic [WIDTH-1:0]   acc_data;
    logic               at_max;
    logic               release_pkt;
    logic               force_rel;

    assign state_dbg = state;

    // State register: async reset drops any packet in flight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: IDLE arbitrates (tie goes to the requester that did not win last), grants release on last or beat limit.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    next_state = last_grant ? GNT0 : GNT1;
                end else if (in0_valid) begin
                    next_state = GNT0;
                end else if (in1_valid) begin
                    next_state = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (release_pkt) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs of the FSM: per-requester ready, the accepted beat, and release decisions.
    always_comb begin
        can_load  = !out_valid || out_ready;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        acc       = 1'b0;
        acc_src   = 1'b0;
        acc_last  = 1'b0;
        acc_data  = '0;
        case (state)
            GNT0: begin
                in0_ready = in0_valid && can_load;
                acc       = in0_valid && can_load;
                acc_src   = 1'b0;
                acc_last  = in0_last;
                acc_data  = in0_data;
            end
            GNT1: begin
                in1_ready = in1_valid && can_load;
                acc       = in1_valid && can_load;
                acc_src   = 1'b1;
                acc_last  = in1_last;
                acc_data  = in1_data;
            end
            default: ;
        endcase
        at_max      = (beat_cnt == CNT_W'(MAX_BEATS - 1));
        release_pkt = acc && (acc_last || at_max);
        force_rel   = acc && !acc_last && at_max;
    end

    // Output register, beat counter, grant history and mux select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= 1'b0;
            out_last   <= 1'b0;
            overrun    <= 1'b0;
            mux_sel    <= 1'b0;
            beat_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            // Overrun lines up with the out_valid of the beat that hit the limit.
            overrun <= force_rel;
            if (acc) begin
                out_valid <= 1'b1;
                out_data  <= acc_data;
                out_src   <= acc_src;
                out_last  <= acc_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (release_pkt) begin
                beat_cnt   <= '0;
                last_grant <= acc_src;
            end else if (acc) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            // The select only moves when a new grant is issued; IDLE keeps the old value.
            if (state == IDLE && next_state != IDLE) begin
                mux_sel <= (next_state == GNT1);
            end
        end
    end

`ifdef MUX_ARB_STATS_EN
    // Saturating count of packet releases per requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (release_pkt) begin
            if (!acc_src && pkt_cnt0 != 32'hFFFF_FFFF) begin
                pkt_cnt0 <= pkt_cnt0 + 32'd1;
            end
            if (acc_src && pkt_cnt1 != 32'hFFFF_FFFF) begin
                pkt_cnt1 <= pkt_cnt1 + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mux64_rr_arbiter.md
Name: mux64_rr_arbiter

Overview:
- Round-robin arbiter that shares one 64-bit 2:1 datapath mux between two requesters (for example, fetch-side and memory-side producers) feeding a single downstream consumer.
- Owns the mux select line: it decides which requester drives the shared bus, latches the selected word into a registered output stage, and holds the grant for the length of a multi-beat packet.
- Sits between the producers and the writeback/bus consumer in the processor datapath.

Parameters:
WIDTH, 64, data width of each requester and of the output.
MAX_BEATS, 16, maximum beats per grant before forced release (must be ≥1).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in0_valid  input  1  requester 0 has a beat.
in0_data  input  WIDTH  requester 0 beat data.
in0_last  input  1  final beat of requester 0 packet.
in0_ready  output  1  requester 0 beat accepted this cycle.
in1_valid  input  1  requester 1 has a beat.
in1_data  input  WIDTH  requester 1 beat data.
in1_last  input  1  final beat of requester 1 packet.
in1_ready  output  1  requester 1 beat accepted this cycle.
out_valid  output  1  output register holds a beat.
out_data  output  WIDTH  registered beat.
out_src  output  1  source of out_data (0 or 1).
out_last  output  1  registered copy of in*_last.
out_ready  input  1  consumer accepts beat.
mux_sel  output  1  current datapath mux select (equals grant index).
overrun  output  1  one-cycle pulse on forced release at MAX_BEATS.

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid, out_data, out_src, out_last, mux_sel, overrun, in0_ready and in1_ready all 0; beat counter 0; last_grant=1, so requester 0 wins the first tie. Reset mid-packet discards everything in flight.
- States: IDLE, GNT0, GNT1.
- IDLE: in*_ready=0.
  - Only in0_valid → GNT0 next cycle.
  - Only in1_valid → GNT1 next cycle.
  - Both valid → grant the index ≠ last_grant.
  - Neither valid → stay in IDLE.
  - Arbitration costs 1 cycle, so there is exactly one bubble between packets.
- GNTi:
  - mux_sel=i.
  - ini_ready = ini_valid && (!out_valid || out_ready); the other requester's ready=0.
  - Accept: ini_valid && ini_ready. On accept, the next edge loads out_data=ini_data, out_src=i, out_last=ini_last, out_valid=1, and increments the beat counter.
  - If no accept and out_ready=1, the next edge clears out_valid.
  - Latency: accept at cycle N → out_valid at N+1.
- Release from GNTi to IDLE, with last_grant=i and counter cleared, when either:
  - an accepted beat has ini_last=1, or
  - the accepted beat is number MAX_BEATS without last. In this case overrun pulses for 1 cycle, aligned with that beat's out_valid.
- Requester deasserts valid mid-packet: grant is held, no timeout, and the other requester waits.
- Backpressure: when out_valid=1 and out_ready=0, the output register is frozen and in*_ready=0. No data is lost or duplicated.
- Output beat ordering matches acceptance order exactly. Beats from the two requesters never interleave within a packet.
- mux_sel changes only on IDLE→GNTi transitions and holds its value through IDLE.

Optional Feature:
MUX_ARB_STATS_EN:
- Defined: adds output ports pkt_cnt0 and pkt_cnt1 (32 bits each), counting releases per requester (last-beat or forced).
  - Both reset to 0.
  - Each saturates at 0xFFFFFFFF.
  - Each updates on the same edge as the release.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then in0 single beat (data 0x1111_2222_3333_4444, last=1), out_ready=1 → GNT0 at cycle 1, in0_ready at cycle 1, out_valid/out_data/out_src=0 at cycle 2, back to IDLE at cycle 2.
- Both requesters valid continuously with 1-beat packets, out_ready=1 → out_src sequence 0,1,0,1…, one bubble between beats, mux_sel toggles each grant.
- in1 3-beat packet (0xA, 0xB, 0xC, last on 0xC) while in0 is also valid → out_data 0xA, 0xB, 0xC all with out_src=1 before any in0 beat appears.
- out_ready held 0 for 4 cycles mid-packet → out_data stable, in*_ready=0 throughout; resume gives no lost or duplicated beats.
- in0 streams 20 beats with last never asserted, MAX_BEATS=16 → overrun pulses with beat 16, grant passes to pending in1, and in0 is re-granted afterward starting at beat 17.
- Assert rst_n=0 asynchronously mid-packet in GNT1 → all outputs 0 immediately without waiting for a clock edge; after release, a tie is granted to in0.
